// File: rtl/ball_ctrl.sv
// Ball motion and collision engine for the paddle game.
// Steps the ball one pixel per axis on every move tick, bounces it off the walls and the
// paddle, and tracks serves, misses and remaining lives.
//
// Ports:
//   clk_i           system clock
//   rst_ni          asynchronous active-low reset
//   pause_i         level; freezes tick counter and ball while high
//   serve_i         one-cycle pulse; launches the ball, or restarts after game over
//   paddle_x_i      paddle left edge
//   paddle_width_i  paddle width in pixels
//   ball_x_o        ball left edge
//   ball_y_o        ball top edge
//   dx_neg_o        ball moving left
//   dy_neg_o        ball moving up
//   hit_pulse_o     one cycle on a paddle bounce
//   miss_pulse_o    one cycle when the ball is lost
//   lives_o         remaining lives
//   game_over_o     high while the game is over
module ball_ctrl #(
  parameter int unsigned SCREEN_W  = 640,
  parameter int unsigned SCREEN_H  = 480,
  parameter int unsigned BALL_SIZE = 8,
  parameter int unsigned PADDLE_Y  = 440,
  parameter int unsigned TICK_DIV  = 416667,
  parameter int unsigned LIVES     = 3
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       pause_i,
  input  logic       serve_i,
  input  logic [9:0] paddle_x_i,
  input  logic [9:0] paddle_width_i,
  output logic [9:0] ball_x_o,
  output logic [9:0] ball_y_o,
  output logic       dx_neg_o,
  output logic       dy_neg_o,
  output logic       hit_pulse_o,
  output logic       miss_pulse_o,
  output logic [1:0] lives_o,
  output logic       game_over_o
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [CntW-1:0] CntLast   = CntW'(TICK_DIV - 1);
  localparam logic [10:0]     XMax      = 11'(SCREEN_W - BALL_SIZE);
  localparam logic [10:0]     YMax      = 11'(SCREEN_H - BALL_SIZE);
  localparam logic [10:0]     BallSz    = 11'(BALL_SIZE);
  localparam logic [10:0]     BallHalf  = 11'(BALL_SIZE / 2);
  localparam logic [10:0]     PadRow    = 11'(PADDLE_Y);
  localparam logic [9:0]      XRst      = 10'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [9:0]      YServe    = 10'(PADDLE_Y - BALL_SIZE);
  localparam logic [1:0]      LivesInit = 2'(LIVES);

  typedef enum logic [1:0] {StServe, StPlay, StOver} state_e;

  state_e          state_q, state_d;
  logic [9:0]      x_q, x_d, y_q, y_d;
  logic            dx_neg_q, dx_neg_d, dy_neg_q, dy_neg_d;
  logic            hit_q, hit_d, miss_q, miss_d;
  logic [1:0]      lives_q, lives_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // All geometry is done 11 bits wide so sums of 10-bit operands never wrap.
  logic [10:0] x_ext, y_ext, px_ext, pw_ext, center, serve_x;
  logic        paddle_hit;

  assign x_ext  = {1'b0, x_q};
  assign y_ext  = {1'b0, y_q};
  assign px_ext = {1'b0, paddle_x_i};
  assign pw_ext = {1'b0, paddle_width_i};
  assign center = px_ext + {2'b00, paddle_width_i[9:1]};

  // Ball centred over the paddle, clamped inside the playfield.
  always_comb begin
    if (center < BallHalf) begin
      serve_x = '0;
    end else if (center - BallHalf > XMax) begin
      serve_x = XMax;
    end else begin
      serve_x = center - BallHalf;
    end
  end

  assign paddle_hit = (x_ext + BallSz > px_ext) && (x_ext < px_ext + pw_ext);

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    dx_neg_d = dx_neg_q;
    dy_neg_d = dy_neg_q;
    lives_d  = lives_q;
    cnt_d    = cnt_q;
    hit_d    = 1'b0;
    miss_d   = 1'b0;
    unique case (state_q)
      StServe: begin
        x_d = serve_x[9:0];
        y_d = YServe;
        if (serve_i && !pause_i) begin
          state_d  = StPlay;
          dx_neg_d = 1'b0;
          dy_neg_d = 1'b1;
          cnt_d    = '0;
        end
      end
      StPlay: begin
        if (!pause_i) begin
          if (cnt_q == CntLast) begin
            cnt_d = '0;
            // X axis: bounce at a wall leaves the position unchanged for this step.
            if (dx_neg_q && x_q == 10'd0) begin
              dx_neg_d = 1'b0;
            end else if (!dx_neg_q && x_ext == XMax) begin
              dx_neg_d = 1'b1;
            end else if (dx_neg_q) begin
              x_d = x_q - 10'd1;
            end else begin
              x_d = x_q + 10'd1;
            end
            // Y axis in priority order: ceiling, paddle, floor, free move.
            if (dy_neg_q && y_q == 10'd0) begin
              dy_neg_d = 1'b0;
            end else if (!dy_neg_q && (y_ext + BallSz == PadRow) && paddle_hit) begin
              dy_neg_d = 1'b1;
              hit_d    = 1'b1;
            end else if (!dy_neg_q && y_ext == YMax) begin
              miss_d  = 1'b1;
              lives_d = lives_q - 2'd1;
              state_d = (lives_q == 2'd1) ? StOver : StServe;
            end else if (dy_neg_q) begin
              y_d = y_q - 10'd1;
            end else begin
              y_d = y_q + 10'd1;
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StOver: begin
        if (serve_i) begin
          lives_d = LivesInit;
          state_d = StServe;
        end
      end
      default: state_d = StServe;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StServe;
      x_q      <= XRst;
      y_q      <= YServe;
      dx_neg_q <= 1'b0;
      dy_neg_q <= 1'b1;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
      lives_q  <= LivesInit;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      dx_neg_q <= dx_neg_d;
      dy_neg_q <= dy_neg_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
      lives_q  <= lives_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ball_x_o     = x_q;
  assign ball_y_o     = y_q;
  assign dx_neg_o     = dx_neg_q;
  assign dy_neg_o     = dy_neg_q;
  assign hit_pulse_o  = hit_q;
  assign miss_pulse_o = miss_q;
  assign lives_o      = lives_q;
  assign game_over_o  = (state_q == StOver);

endmodule

// File: tb/tb_ball_ctrl.sv
// Self-checking bench for ball_ctrl: serve-position table, directed rally sequences and a
// randomized run, all compared cycle by cycle against a behavioural model of the game.
module tb_ball_ctrl;
  localparam int W  = 640;
  localparam int H  = 480;
  localparam int BS = 8;
  localparam int PY = 440;
  localparam int TD = 4;
  localparam int LV = 3;

  logic       clk;
  logic       rst_n;
  logic       pause;
  logic       serve;
  logic [9:0] px;
  logic [9:0] pw;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic       dx_neg;
  logic       dy_neg;
  logic       hit_pulse;
  logic       miss_pulse;
  logic [1:0] lives;
  logic       game_over;

  ball_ctrl #(
    .SCREEN_W (W),
    .SCREEN_H (H),
    .BALL_SIZE(BS),
    .PADDLE_Y (PY),
    .TICK_DIV (TD),
    .LIVES    (LV)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .pause_i       (pause),
    .serve_i       (serve),
    .paddle_x_i    (px),
    .paddle_width_i(pw),
    .ball_x_o      (ball_x),
    .ball_y_o      (ball_y),
    .dx_neg_o      (dx_neg),
    .dy_neg_o      (dy_neg),
    .hit_pulse_o   (hit_pulse),
    .miss_pulse_o  (miss_pulse),
    .lives_o       (lives),
    .game_over_o   (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: 0 = waiting to serve, 1 = in play, 2 = game over; velocities are +1 / -1.
  int m_state, m_x, m_y, m_vx, m_vy, m_lives, m_cnt, m_hit, m_miss;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_x = (W - BS) / 2; m_y = PY - BS; m_vx = 1; m_vy = -1;
    m_lives = LV; m_cnt = 0; m_hit = 0; m_miss = 0;
  endtask

  task automatic model_step();
    int ox, c;
    m_hit  = 0;
    m_miss = 0;
    case (m_state)
      0: begin
        m_y = PY - BS;
        c = int'(px) + int'(pw) / 2 - BS / 2;
        if (c < 0) c = 0;
        if (c > W - BS) c = W - BS;
        m_x = c;
        if (serve && !pause) begin
          m_state = 1; m_vx = 1; m_vy = -1; m_cnt = 0;
        end
      end
      1: begin
        if (!pause) begin
          if (m_cnt == TD - 1) begin
            m_cnt = 0;
            ox = m_x;
            if (m_vx < 0 && ox == 0) m_vx = 1;
            else if (m_vx > 0 && ox == W - BS) m_vx = -1;
            else m_x = ox + m_vx;
            if (m_vy < 0 && m_y == 0) m_vy = 1;
            else if (m_vy > 0 && m_y + BS == PY && ox + BS > int'(px) &&
                     ox < int'(px) + int'(pw)) begin
              m_vy = -1; m_hit = 1;
            end else if (m_vy > 0 && m_y == H - BS) begin
              m_miss = 1;
              m_lives--;
              m_state = (m_lives == 0) ? 2 : 0;
            end else m_y += m_vy;
          end else begin
            m_cnt++;
          end
        end
      end
      default: begin
        if (serve) begin
          m_lives = LV; m_state = 0;
        end
      end
    endcase
  endtask

  task automatic check_all();
    chk("ball_x", ball_x, m_x);
    chk("ball_y", ball_y, m_y);
    chk("dx_neg", dx_neg, m_vx < 0);
    chk("dy_neg", dy_neg, m_vy < 0);
    chk("hit_pulse", hit_pulse, m_hit);
    chk("miss_pulse", miss_pulse, m_miss);
    chk("lives", lives, m_lives);
    chk("game_over", game_over, m_state == 2);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic serve_pulse();
    serve = 1'b1;
    cyc();
    serve = 1'b0;
  endtask

  // Run until the model ball has just arrived on the paddle row moving down.
  task automatic wait_paddle_row();
    bit ok = 1'b0;
    for (int i = 0; i < 8000; i++) begin
      cyc();
      if (m_state == 1 && m_y == PY - BS && m_vy > 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("reach_paddle_row", ok, 1);
  endtask

  task automatic do_miss(input int exp_lives);
    bit ok = 1'b0;
    wait_paddle_row();
    px = (m_x < 500) ? 10'(m_x + 100) : 10'(m_x - 200);
    pw = 10'd64;
    for (int i = 0; i < 400; i++) begin
      cyc();
      if (miss_pulse) begin
        ok = 1'b1;
        break;
      end
    end
    chk("miss_seen", ok, 1);
    chk("miss_lives", lives, exp_lives);
    cyc();
    chk("miss_pulse_width", miss_pulse, 0);
  endtask

  typedef struct {
    logic [9:0] px;
    logic [9:0] pw;
    logic       pause;
    logic       serve;
    int         exp_x;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    int hits, fx;
    tbl[0] = '{10'd300,  10'd64,   1'b0, 1'b0, 328};
    tbl[1] = '{10'd0,    10'd0,    1'b0, 1'b0, 0};
    tbl[2] = '{10'd0,    10'd4,    1'b0, 1'b0, 0};
    tbl[3] = '{10'd0,    10'd8,    1'b0, 1'b0, 0};
    tbl[4] = '{10'd1,    10'd8,    1'b1, 1'b1, 1};
    tbl[5] = '{10'd630,  10'd64,   1'b0, 1'b0, 632};
    tbl[6] = '{10'd1023, 10'd1023, 1'b0, 1'b0, 632};
    tbl[7] = '{10'd600,  10'd72,   1'b0, 1'b0, 632};
    tbl[8] = '{10'd600,  10'd70,   1'b0, 1'b0, 631};
    tbl[9] = '{10'd100,  10'd1,    1'b0, 1'b0, 96};

    rst_n = 1'b0; pause = 1'b0; serve = 1'b0; px = 10'd300; pw = 10'd64;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("reset_x", ball_x, 316);
    chk("reset_y", ball_y, 432);
    rst_n = 1'b1;
    cyc();
    chk("serve_x", ball_x, 328);
    chk("serve_y", ball_y, 432);
    chk("serve_lives", lives, 3);
    chk("serve_over", game_over, 0);

    // Serve-position clamping, including a serve blocked by pause.
    foreach (tbl[i]) begin
      px = tbl[i].px; pw = tbl[i].pw; pause = tbl[i].pause; serve = tbl[i].serve;
      cyc();
      chk("tbl_x", ball_x, tbl[i].exp_x);
      chk("tbl_y", ball_y, 432);
    end
    pause = 1'b0; serve = 1'b0;

    // Launch: first step lands four clocks after entering play.
    px = 10'd300; pw = 10'd64;
    serve_pulse();
    repeat (3) cyc();
    chk("pre_tick_x", ball_x, 328);
    cyc();
    chk("tick1_x", ball_x, 329);
    chk("tick1_y", ball_y, 431);
    repeat (12) cyc();
    chk("tick4_x", ball_x, 332);
    chk("tick4_y", ball_y, 428);

    // Paddle hit: ball 10 px right of paddle edge.
    wait_paddle_row();
    px = 10'(m_x >= 10 ? m_x - 10 : 0);
    pw = 10'd64;
    hits = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (hit_pulse) hits++;
    end
    chk("hit_count", hits, 1);
    chk("hit_dy_neg", dy_neg, 1);

    do_miss(2);
    chk("after_miss_over", game_over, 0);
    chk("after_miss_y", ball_y, 432);

    // Corner: serve from x=200 reaches (632,0) after 432 steps.
    px = 10'd172; pw = 10'd64;
    cyc();
    serve_pulse();
    chk("corner_start_x", ball_x, 200);
    repeat (432 * TD) cyc();
    chk("corner_x", ball_x, 632);
    chk("corner_y", ball_y, 0);
    chk("corner_dx", dx_neg, 0);
    chk("corner_dy", dy_neg, 1);
    repeat (TD) cyc();
    chk("flip_x", ball_x, 632);
    chk("flip_y", ball_y, 0);
    chk("flip_dx", dx_neg, 1);
    chk("flip_dy", dy_neg, 0);
    repeat (TD) cyc();
    chk("after_flip_x", ball_x, 631);
    chk("after_flip_y", ball_y, 1);

    // Pause mid-flight, started part-way through a tick period.
    cyc();
    pause = 1'b1;
    repeat (20) cyc();
    chk("pause_x", ball_x, 631);
    chk("pause_y", ball_y, 1);
    pause = 1'b0;
    repeat (8) cyc();

    do_miss(1);
    px = 10'd300; pw = 10'd64;
    serve_pulse();
    do_miss(0);
    chk("over_flag", game_over, 1);
    fx = m_x;
    px = 10'd50;
    repeat (20) cyc();
    chk("over_frozen_x", ball_x, fx);
    chk("over_lives", lives, 0);
    serve_pulse();
    chk("restart_lives", lives, 3);
    chk("restart_over", game_over, 0);

    // Randomized play.
    for (int i = 0; i < 4000; i++) begin
      serve = ($urandom_range(15) == 0);
      if ($urandom_range(19) == 0) pause = ~pause;
      if ($urandom_range(49) == 0) begin
        px = 10'($urandom_range(1023));
        pw = 10'($urandom_range(160));
      end
      cyc();
    end
    serve = 1'b0; pause = 1'b0;

    // Asynchronous reset mid-flight.
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    px = 10'd300; pw = 10'd64;
    cyc();
    serve_pulse();
    repeat (10) cyc();
    chk("flight_x", ball_x, 330);
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("async_x", ball_x, 316);
    chk("async_y", ball_y, 432);
    chk("async_lives", lives, 3);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ball_ctrl.md
Name: ball_ctrl

Overview:
- Ball motion and collision engine for the paddle game; sits directly downstream of the paddle position stage.
- Consumes the paddle's x position and width each cycle, steps the ball one pixel per axis per move tick, and bounces it off walls and the paddle.
- Tracks serves, misses and lives. Feeds ball_x/ball_y to the renderer and hit/miss pulses to scoring.

Parameters:
- SCREEN_W, 640, playfield width in pixels
- SCREEN_H, 480, playfield height in pixels
- BALL_SIZE, 8, ball square side in pixels
- PADDLE_Y, 440, top row of paddle
- TICK_DIV, 416667, clk cycles per move step (100 MHz / 240 Hz); benches use 4
- LIVES, 3, lives at reset/restart (1..3)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- pause  in  1  level; freezes tick counter and ball while 1
- serve  in  1  single-cycle pulse; launches ball or restarts after game over
- paddle_x  in  10  paddle left edge from paddle stage
- paddle_width  in  10  paddle width in pixels
- ball_x  out  10  ball left edge
- ball_y  out  10  ball top edge
- dx_neg  out  1  1 = moving left
- dy_neg  out  1  1 = moving up
- hit_pulse  out  1  one cycle on paddle bounce
- miss_pulse  out  1  one cycle on ball lost
- lives  out  2  remaining lives
- game_over  out  1  high in OVER state

Behaviour:
- Reset (reset=0, async):
  - state=SERVE, lives=LIVES, dx_neg=0, dy_neg=1.
  - ball_x=(SCREEN_W-BALL_SIZE)/2, ball_y=PADDLE_Y-BALL_SIZE.
  - Pulses 0, tick counter 0.
  - Reset mid-play aborts the rally immediately.
- All sums/compares use 11-bit zero-extended arithmetic; no wrap.
- Tick counter: counts 0..TICK_DIV-1 only in PLAY with pause=0, held otherwise (not cleared by pause). tick=1 in the cycle counter==TICK_DIV-1, then counter wraps to 0.
- SERVE:
  - Each cycle ball_y=PADDLE_Y-BALL_SIZE.
  - ball_x=paddle_x+paddle_width/2-BALL_SIZE/2, clamped to [0, SCREEN_W-BALL_SIZE].
  - serve=1 and pause=0 -> PLAY next cycle with dx_neg=0, dy_neg=1, counter=0.
- PLAY, on tick, evaluated from current registered values:
  - X axis:
    - dx_neg=1 and ball_x==0 -> dx_neg=0, x unchanged.
    - dx_neg=0 and ball_x==SCREEN_W-BALL_SIZE -> dx_neg=1, x unchanged.
    - Otherwise x±1.
  - Y axis, priority order:
    - (a) dy_neg=1 and ball_y==0 -> dy_neg=0, y unchanged.
    - (b) Paddle hit: dy_neg=0 and ball_y+BALL_SIZE==PADDLE_Y and ball_x+BALL_SIZE>paddle_x and ball_x<paddle_x+paddle_width -> dy_neg=1, y unchanged, hit_pulse=1 for one cycle.
    - (c) dy_neg=0 and ball_y==SCREEN_H-BALL_SIZE -> miss.
    - (d) Otherwise y±1.
  - Axes are independent: a corner flips both on the same tick.
  - Miss: miss_pulse=1 one cycle; lives-1; new lives==0 -> OVER, else SERVE.
- pause=1 in PLAY: position, direction and counter hold; no pulses.
- OVER:
  - game_over=1, ball frozen, lives=0.
  - serve=1 -> lives=LIVES, state SERVE.
- serve ignored in PLAY. hit_pulse and miss_pulse are never both 1.
- Outputs are registered; a tick updates position one cycle after the tick cycle.

Test Plan:
- Reset then release, paddle_x=300, paddle_width=64 -> ball_x=328, ball_y=432, lives=3, game_over=0.
- serve pulse, TICK_DIV=4 -> PLAY; after 4 ticks, ball_x=332 and ball_y=428; one tick every 4 clks.
- Force ball to (632,0) moving right/up; next tick -> dx_neg=1, dy_neg=0, position unchanged; following tick -> (631,1).
- Ball at y=432 moving down, ball_x=310, paddle_x=300 -> hit_pulse single cycle, dy_neg=1. Repeat with paddle_x=400 -> no hit; ball reaches y=472, miss_pulse fires, lives=2, state SERVE.
- Three consecutive misses -> game_over=1, ball frozen; serve -> lives=3, SERVE.
- Hold pause=1 for 20 clks mid-flight -> no position change, counter held; assert reset=0 mid-flight -> outputs return to reset values immediately without waiting for a clk edge.
